// File: rtl/button_debounce_multi.sv
// N-channel push-button conditioner: 2-flop synchronizer, restart-on-bounce debounce, press/click/release/long events.
// Define BUTTON_AUTO_REPEAT_EN to make o_long repeat every REPEAT_CYCLES while a long press is held.
module button_debounce_multi #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int LONG_CYCLES     = 500000,
  parameter int REPEAT_CYCLES   = 100000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [N_BUTTONS-1:0] i_button,
  output logic [N_BUTTONS-1:0] o_level,
  output logic [N_BUTTONS-1:0] o_press,
  output logic [N_BUTTONS-1:0] o_click,
  output logic [N_BUTTONS-1:0] o_release,
  output logic [N_BUTTONS-1:0] o_long
);

  localparam int MAX_DL     = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int MAX_CYCLES = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESS_DEB   = 3'd1,
    HELD        = 3'd2,
    LONG_HELD   = 3'd3,
    RELEASE_DEB = 3'd4
  } state_t;

  logic [N_BUTTONS-1:0] sync1_r;
  logic [N_BUTTONS-1:0] sync2_r;

  // Two-flop synchronizer for the asynchronous button pins.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= i_button;
      sync2_r <= sync1_r;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_BUTTONS; g++) begin : g_chan
      state_t           state_r;
      logic [CNT_W-1:0] cnt_r;
      logic             was_long_r;
      logic             level_r;
      logic             press_r;
      logic             click_r;
      logic             release_r;
      logic             long_r;
      logic             s;

      assign s = sync2_r[g];

      // Per-channel debounce FSM; every counter stops at its compare value, so none can wrap.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          state_r    <= IDLE;
          cnt_r      <= '0;
          was_long_r <= 1'b0;
          level_r    <= 1'b0;
          press_r    <= 1'b0;
          click_r    <= 1'b0;
          release_r  <= 1'b0;
          long_r     <= 1'b0;
        end else begin
          press_r   <= 1'b0;
          click_r   <= 1'b0;
          release_r <= 1'b0;
          long_r    <= 1'b0;
          case (state_r)
            IDLE: begin
              if (s) begin
                state_r <= PRESS_DEB;
                cnt_r   <= CNT_W'(1);
              end
            end
            PRESS_DEB: begin
              if (!s) begin
                state_r <= IDLE;
                cnt_r   <= '0;
              end else if (cnt_r == DEB_MAX) begin
                state_r <= HELD;
                cnt_r   <= '0;
                level_r <= 1'b1;
                press_r <= 1'b1;
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
            HELD: begin
              if (!s) begin
                state_r    <= RELEASE_DEB;
                cnt_r      <= CNT_W'(1);
                was_long_r <= 1'b0;
              end else if (cnt_r == LONG_LAST) begin
                state_r <= LONG_HELD;
                cnt_r   <= '0;
                long_r  <= 1'b1;
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
            LONG_HELD: begin
              if (!s) begin
                state_r    <= RELEASE_DEB;
                cnt_r      <= CNT_W'(1);
                was_long_r <= 1'b1;
              end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
                if (cnt_r == REP_LAST) begin
                  cnt_r  <= '0;
                  long_r <= 1'b1;
                end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
                end
`else
                cnt_r <= cnt_r;
`endif
              end
            end
            RELEASE_DEB: begin
              // A bounce back high resumes the held phase with a fresh long/repeat timer.
              if (s) begin
                state_r <= was_long_r ? LONG_HELD : HELD;
                cnt_r   <= '0;
              end else if (cnt_r == DEB_MAX) begin
                state_r   <= IDLE;
                cnt_r     <= '0;
                level_r   <= 1'b0;
                release_r <= 1'b1;
                click_r   <= ~was_long_r;
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
            default: begin
              state_r <= IDLE;
              cnt_r   <= '0;
              level_r <= 1'b0;
            end
          endcase
        end
      end

      assign o_level[g]   = level_r;
      assign o_press[g]   = press_r;
      assign o_click[g]   = click_r;
      assign o_release[g] = release_r;
      assign o_long[g]    = long_r;
    end
  endgenerate

endmodule

// File: tb/tb_button_debounce_multi.sv
// Scoreboard bench for button_debounce_multi: a run-length reference model pushes expected outputs per edge,
// a monitor pops and compares on the falling edge. Honours BUTTON_AUTO_REPEAT_EN like the design.
module tb_button_debounce_multi;

  localparam int NB  = 2;
  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn = '0;
  logic [NB-1:0] o_level, o_press, o_click, o_release, o_long;

  button_debounce_multi #(
    .N_BUTTONS(NB), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_button(btn),
    .o_level(o_level), .o_press(o_press), .o_click(o_click),
    .o_release(o_release), .o_long(o_long)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] click;
    logic [NB-1:0] rel;
    logic [NB-1:0] lng;
  } exp_t;

  exp_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  // Reference model state: accepted level plus run lengths of the synchronized samples.
  logic [NB-1:0] m_ff1 = '0;
  logic [NB-1:0] m_ff2 = '0;
  bit            lvl[NB];
  bit            long_done[NB];
  bit            prev_s[NB];
  int            diff_run[NB];
  int            hold_run[NB];

  task automatic model_step();
    exp_t          e;
    logic [NB-1:0] s;
    e = '0;
    if (rst) begin
      m_ff1 = '0;
      m_ff2 = '0;
      for (int c = 0; c < NB; c++) begin
        lvl[c] = 1'b0; long_done[c] = 1'b0; prev_s[c] = 1'b0;
        diff_run[c] = 0; hold_run[c] = 0;
      end
    end else begin
      s     = m_ff2;
      m_ff2 = m_ff1;
      m_ff1 = btn;
      for (int c = 0; c < NB; c++) begin
        if (s[c] != lvl[c]) diff_run[c]++;
        else diff_run[c] = 0;
        if (diff_run[c] == DEB + 1) begin
          // DEB+1 consecutive samples disagreeing with the accepted level flip it.
          diff_run[c] = 0;
          lvl[c]      = s[c];
          if (s[c]) begin
            e.press[c]   = 1'b1;
            long_done[c] = 1'b0;
            hold_run[c]  = 0;
          end else begin
            e.rel[c]   = 1'b1;
            e.click[c] = !long_done[c];
          end
        end else if (lvl[c] && s[c]) begin
          if (prev_s[c]) begin
            hold_run[c]++;
            if (!long_done[c] && hold_run[c] == LNG) begin
              e.lng[c] = 1'b1; long_done[c] = 1'b1; hold_run[c] = 0;
            end
`ifdef BUTTON_AUTO_REPEAT_EN
            else if (long_done[c] && hold_run[c] == REP) begin
              e.lng[c] = 1'b1; hold_run[c] = 0;
            end
`endif
          end else begin
            hold_run[c] = 0;
          end
        end
        prev_s[c] = s[c];
      end
    end
    for (int c = 0; c < NB; c++) e.level[c] = lvl[c];
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: one expected entry per clock edge, compared away from the edge.
  initial begin
    exp_t want;
    exp_t got;
    forever begin
      @(negedge clk);
      got = {o_level, o_press, o_click, o_release, o_long};
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL scoreboard_empty @%0t: got %h with no expected entry", $time, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          mismatched++;
          $display("FAIL outputs @%0t: got lvl=%b prs=%b clk=%b rel=%b lng=%b, want lvl=%b prs=%b clk=%b rel=%b lng=%b",
                   $time, got.level, got.press, got.click, got.rel, got.lng,
                   want.level, want.press, want.click, want.rel, want.lng);
        end
      end
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_for(input int ch, input bit want_long, input int expect_n, input string name);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (want_long ? o_long[ch] : o_press[ch]) seen = 1'b1;
    end
    compared++;
    if (!seen || n != expect_n) begin
      mismatched++;
      $display("FAIL %s: got %0d cycles (seen=%0b), want %0d", name, n, seen, expect_n);
    end
  endtask

  task automatic pulse_reset(input int hold);
    rst = 1'b1;
    #1;
    compared++;
    if ({o_level, o_press, o_click, o_release, o_long} !== '0) begin
      mismatched++;
      $display("FAIL reset_immediate: got %h, want 0", {o_level, o_press, o_click, o_release, o_long});
    end
    cycle(hold);
    rst = 1'b0;
  endtask

  initial begin
    int rem[NB];
    cycle(3);
    rst = 1'b0;
    cycle(5);

    // Clean short press on ch0: press latency, then click + release.
    btn[0] = 1'b1;
    wait_for(0, 1'b0, DEB + 3, "press_latency_ch0");
    cycle(6);
    btn[0] = 1'b0;
    cycle(15);

    // Bounce on ch0, then a steady hold.
    for (int i = 0; i < 4; i++) begin
      btn[0] = ~btn[0];
      cycle(2);
    end
    btn[0] = 1'b1;
    wait_for(0, 1'b0, DEB + 3, "press_after_bounce_ch0");
    cycle(6);
    btn[0] = 1'b0;
    cycle(15);

    // Long press on ch1.
    btn[1] = 1'b1;
    wait_for(1, 1'b0, DEB + 3, "press_latency_ch1");
    wait_for(1, 1'b1, LNG, "long_latency_ch1");
    cycle(12);
    btn[1] = 1'b0;
    cycle(15);

    // Release bounce while held on ch0.
    btn[0] = 1'b1;
    cycle(12);
    btn[0] = 1'b0;
    cycle(2);
    btn[0] = 1'b1;
    cycle(10);
    btn[0] = 1'b0;
    cycle(15);

    // Reset with ch0 in HELD and ch1 in PRESS_DEB, both still high afterwards.
    btn[0] = 1'b1;
    cycle(10);
    btn[1] = 1'b1;
    cycle(3);
    pulse_reset(2);
    wait_for(0, 1'b0, DEB + 3, "press_after_reset_ch0");
    cycle(4);
    btn = '0;
    cycle(15);

    // Simultaneous press on both channels.
    btn = 2'b11;
    cycle(10);
    btn = 2'b00;
    cycle(15);

    // Randomized segment with mixed bounces, short and long holds.
    for (int c = 0; c < NB; c++) rem[c] = 1;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NB; c++) begin
        rem[c]--;
        if (rem[c] <= 0) begin
          btn[c] = ~btn[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 8));
        end
      end
      if (i == 700) pulse_reset(2);
      cycle(1);
    end
    btn = '0;
    cycle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/button_debounce_multi.md
Name: button_debounce_multi

Overview:
- N-channel push-button conditioner: per-channel 2-flop synchronizer, bounce-rejecting debounce FSM, and press/click/release/long-press event generation.
- Successor to the single-button release-pulse debouncer. Adds channel count, restart-on-bounce debounce, a stable level output and long-press detection.
- Sits between board button pins and the light-stand mode FSM / PWM controls.

Parameters:
- N_BUTTONS, 4, number of independent channels (>=1).
- DEBOUNCE_CYCLES, 5000, consecutive stable synchronized samples needed to accept an edge (>=1; 10 ms at 500 kHz).
- LONG_CYCLES, 500000, cycles in HELD before a long press is declared (>=2).
- REPEAT_CYCLES, 100000, auto-repeat period in LONG_HELD (>=2; used only with the optional feature).
- CNT_W, derived, $clog2 of max(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES) plus 1. Localparam, not overridable.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_button  in  N_BUTTONS  raw active-high button inputs, asynchronous to i_clk.
- o_level  out  N_BUTTONS  debounced level; 1 in HELD, LONG_HELD and RELEASE_DEB.
- o_press  out  N_BUTTONS  1-cycle pulse when a press is accepted.
- o_click  out  N_BUTTONS  1-cycle pulse on an accepted release when the long threshold was not reached.
- o_release  out  N_BUTTONS  1-cycle pulse on every accepted release.
- o_long  out  N_BUTTONS  1-cycle pulse at the long-press threshold (and on repeats, see Optional Feature).

Behaviour:
- Clock and reset: clock i_clk; reset i_reset, asynchronous, active-high.
- Reset response, taking effect immediately, including mid-operation:
  - all outputs 0;
  - sync flops 0;
  - every channel in IDLE with cnt = 0.
- Channels are fully independent. There is no shared state between channels.
- Synchronizer: i_button[n] -> ff1 -> ff2 = s[n]. A level sampled by ff1 at edge k is seen by the FSM at edge k+2.
- All outputs are registered. Pulse outputs are 0 in every cycle not listed below.
- IDLE:
  - s=1 -> PRESS_DEB, cnt=1.
- PRESS_DEB:
  - s=0 -> IDLE, cnt=0 (bounce restarts the debounce).
  - s=1 and cnt<DEBOUNCE_CYCLES -> cnt+1.
  - s=1 and cnt==DEBOUNCE_CYCLES -> HELD, cnt=0, o_level<=1, o_press<=1.
- HELD:
  - s=1 and cnt<LONG_CYCLES-1 -> cnt+1.
  - s=1 and cnt==LONG_CYCLES-1 -> LONG_HELD, cnt=0, o_long<=1.
  - s=0 -> RELEASE_DEB, cnt=1, was_long=0.
- LONG_HELD:
  - s=1 -> stay.
  - s=0 -> RELEASE_DEB, cnt=1, was_long=1.
- RELEASE_DEB:
  - s=1 -> return to HELD (was_long=0) or LONG_HELD (was_long=1), cnt=0. The long timer restarts after a release bounce.
  - s=0 and cnt<DEBOUNCE_CYCLES -> cnt+1.
  - s=0 and cnt==DEBOUNCE_CYCLES -> IDLE, o_level<=0, o_release<=1, and o_click<=1 if was_long=0.
- Timing, with i_button first sampled high at edge k and held steady:
  - o_press and o_level rise after edge k+2+DEBOUNCE_CYCLES;
  - o_long rises LONG_CYCLES edges after o_press;
  - release latency is symmetric: o_release rises after edge r+2+DEBOUNCE_CYCLES.
- No channel ever emits o_press twice without an intervening o_release.
- Simultaneous events on different channels are all reported in the same cycle.
- Counters never wrap. Each counter saturates at the compare value by construction.

Optional Feature:
- Macro BUTTON_AUTO_REPEAT_EN.
- When defined:
  - in LONG_HELD, cnt counts while s=1;
  - at cnt==REPEAT_CYCLES-1, o_long pulses again and cnt=0, repeating until release;
  - a return from RELEASE_DEB to LONG_HELD restarts the repeat period.
- When undefined: o_long pulses exactly once per press, and REPEAT_CYCLES is unused.

Test Plan:
Bench parameters: N_BUTTONS=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8.
- Clean short press: ch0 high at edge 10 for 12 cycles, then low -> o_press[0] pulses after edge 16, o_level[0]=1 from edge 16; after release, o_release[0] and o_click[0] pulse together once; o_long[0] never pulses.
- Bounce: ch0 toggles 1,0,1,0 every 2 cycles, then holds high from edge 30 -> no event during toggling; o_press[0] pulses after edge 36.
- Long press: ch1 held 40 cycles -> o_long[1] pulses once, 20 cycles after o_press[1]; on release o_release[1] pulses and o_click[1] stays 0. With BUTTON_AUTO_REPEAT_EN, o_long[1] additionally pulses every 8 cycles while held.
- Release bounce: while in HELD, ch0 drops low for 2 cycles then returns high -> o_level[0] stays 1; no o_release or o_click; no second o_press.
- Reset mid-operation: assert i_reset while ch0 is in HELD and ch1 is in PRESS_DEB -> all outputs 0 immediately; after deassert with both inputs still high, each channel re-debounces and o_press pulses DEBOUNCE_CYCLES+2 edges later.
- Simultaneous: both channels rise on the same edge -> o_press=2'b11 in a single cycle.
